// File: rtl/hamming_enc_engine_pkg.sv
// Shared types and helpers for the Hamming (16,11) SECDED encoder engine.
// The parity masks and codeword placement are common to the encoder and the checker.
package hamming_enc_engine_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_LO = 3'd1,
        ST_RD_HI = 3'd2,
        ST_WR_LO = 3'd3,
        ST_WR_HI = 3'd4,
        ST_FIN   = 3'd5
    } state_e;

    // Bit k-1 of each mask selects data bit d[k] of d[11:1].
    localparam logic [10:0] P8_MASK = 11'h7F0;
    localparam logic [10:0] P4_MASK = 11'h78E;
    localparam logic [10:0] P2_MASK = 11'h66D;
    localparam logic [10:0] P1_MASK = 11'h55B;

    function automatic logic masked_parity(input logic [11:1] d, input logic [10:0] mask);
        masked_parity = ^(d & mask);
    endfunction

    function automatic logic [15:0] place_codeword(
        input logic [11:1] d,
        input logic        p8,
        input logic        p4,
        input logic        p2,
        input logic        p1,
        input logic        p0
    );
        place_codeword = {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0};
    endfunction

endpackage

// File: rtl/hamming_enc_engine_if.sv
// Start/done handshake plus byte-wide data-memory port of the encoder engine.
// master is the engine side; slave is the controller/memory side.
interface hamming_enc_engine_if #(
    parameter int AW = 8
);
    logic          start;
    logic          done;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rdata;
    logic [7:0]    mem_wdata;
    logic          mem_we;

    modport master (
        input  start,
        input  mem_rdata,
        output done,
        output mem_addr,
        output mem_wdata,
        output mem_we
    );

    modport slave (
        output start,
        output mem_rdata,
        input  done,
        input  mem_addr,
        input  mem_wdata,
        input  mem_we
    );
endinterface

// File: rtl/hamming_enc_engine_enc11.sv
// Combinational Hamming (16,11) encoder: d[11:1] -> SECDED codeword with even overall parity.
// Also used by the checker to regenerate parity for syndrome computation.
module hamming_enc11
    import hamming_enc_engine_pkg::*;
(
    input  logic [11:1] d,
    output logic [15:0] enc
);
    logic p8_s;
    logic p4_s;
    logic p2_s;
    logic p1_s;
    logic p0_s;

    assign p8_s = masked_parity(d, P8_MASK);
    assign p4_s = masked_parity(d, P4_MASK);
    assign p2_s = masked_parity(d, P2_MASK);
    assign p1_s = masked_parity(d, P1_MASK);
    assign p0_s = ^{d, p8_s, p4_s, p2_s, p1_s};
    assign enc  = place_codeword(d, p8_s, p4_s, p2_s, p1_s, p0_s);
endmodule

// File: rtl/hamming_enc_engine.sv
// Encoder engine: reads NUM_MSG 11-bit messages from byte memory, writes 16-bit SECDED codewords back.
// Memory outputs are registered from the next-state decode so they change only on clk.
module hamming_enc_engine
    import hamming_enc_engine_pkg::*;
#(
    parameter int NUM_MSG  = 15,
    parameter int SRC_BASE = 0,
    parameter int DST_BASE = 30,
    parameter int AW       = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    hamming_enc_engine_if.master bus
);
    localparam int            IW       = $clog2(NUM_MSG) + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_MSG - 1);

    state_e        state_r;
    state_e        state_next_s;
    logic [IW-1:0] idx_r;
    logic [IW-1:0] idx_next_s;
    logic [11:1]   d_r;
    logic [11:1]   d_next_s;
    logic          done_r;
    logic          done_next_s;
    logic [AW-1:0] addr_r;
    logic [AW-1:0] addr_next_s;
    logic [7:0]    wdata_r;
    logic [7:0]    wdata_next_s;
    logic          we_r;
    logic          we_next_s;
    logic [15:0]   enc_s;
    logic [AW-1:0] src_addr_s;
    logic [AW-1:0] dst_addr_s;

    // Encode the data as it will stand after this cycle, so WR_LO can be loaded straight out of RD_HI.
    hamming_enc11 u_enc11 (
        .d   (d_next_s),
        .enc (enc_s)
    );

    assign src_addr_s = AW'(SRC_BASE) + AW'({idx_next_s, 1'b0});
    assign dst_addr_s = AW'(DST_BASE) + AW'({idx_next_s, 1'b0});

    // Sequencer next-state, message index, data latch and done flag.
    always_comb begin
        state_next_s = state_r;
        idx_next_s   = idx_r;
        d_next_s     = d_r;
        done_next_s  = done_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_next_s = ST_RD_LO;
                    idx_next_s   = {IW{1'b0}};
                    done_next_s  = 1'b0;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RD_LO: begin
                d_next_s[8:1] = bus.mem_rdata;
                state_next_s  = ST_RD_HI;
            end
            ST_RD_HI: begin
                d_next_s[11:9] = bus.mem_rdata[2:0];
                state_next_s   = ST_WR_LO;
            end
            ST_WR_LO: begin
                state_next_s = ST_WR_HI;
            end
            ST_WR_HI: begin
                if (idx_r == LAST_IDX) begin
                    state_next_s = ST_FIN;
                end else begin
                    idx_next_s   = idx_r + IW'(1);
                    state_next_s = ST_RD_LO;
                end
            end
            ST_FIN: begin
                done_next_s  = 1'b1;
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Memory-port values for the state about to be entered.
    always_comb begin
        addr_next_s  = {AW{1'b0}};
        wdata_next_s = 8'h00;
        we_next_s    = 1'b0;
        case (state_next_s)
            ST_RD_LO: begin
                addr_next_s = src_addr_s;
            end
            ST_RD_HI: begin
                addr_next_s = src_addr_s + AW'(1);
            end
            ST_WR_LO: begin
                addr_next_s  = dst_addr_s;
                wdata_next_s = enc_s[7:0];
                we_next_s    = 1'b1;
            end
            ST_WR_HI: begin
                addr_next_s  = dst_addr_s + AW'(1);
                wdata_next_s = enc_s[15:8];
                we_next_s    = 1'b1;
            end
            default: begin
                addr_next_s = {AW{1'b0}};
            end
        endcase
    end

    // State and output registers; reset aborts any run in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            idx_r   <= {IW{1'b0}};
            d_r     <= 11'h000;
            done_r  <= 1'b0;
            addr_r  <= {AW{1'b0}};
            wdata_r <= 8'h00;
            we_r    <= 1'b0;
        end else begin
            state_r <= state_next_s;
            idx_r   <= idx_next_s;
            d_r     <= d_next_s;
            done_r  <= done_next_s;
            addr_r  <= addr_next_s;
            wdata_r <= wdata_next_s;
            we_r    <= we_next_s;
        end
    end

    assign bus.done      = done_r;
    assign bus.mem_addr  = addr_r;
    assign bus.mem_wdata = wdata_r;
    assign bus.mem_we    = we_r;
endmodule

// File: tb/tb_hamming_enc_engine.sv
// Self-checking bench for hamming_enc_engine: byte memory model, write monitor and codeword scoreboard.
module tb_hamming_enc_engine;
    localparam int NUM = 15;
    localparam int SRC = 0;
    localparam int DST = 30;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  mem [0:255];
    logic        tb_we;
    logic [7:0]  tb_addr;
    logic [7:0]  tb_data;
    logic [7:0]  msg_lo [NUM];
    logic [7:0]  msg_hi [NUM];
    logic [15:0] exp_q [$];
    logic [15:0] wr_q [$];
    int          checks = 0;
    int          failures = 0;

    hamming_enc_engine_if #(.AW(8)) bus ();

    hamming_enc_engine #(
        .NUM_MSG  (NUM),
        .SRC_BASE (SRC),
        .DST_BASE (DST),
        .AW       (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.mem_rdata = mem[bus.mem_addr];

    always @(posedge clk) begin
        if (bus.mem_we === 1'b1) mem[bus.mem_addr] <= bus.mem_wdata;
        else if (tb_we) mem[tb_addr] <= tb_data;
    end

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) wr_q.push_back({bus.mem_addr, bus.mem_wdata});
    end

    // Reference encoder written directly from the parity equations.
    function automatic logic [15:0] model_enc(input logic [11:1] d);
        logic p8, p4, p2, p1, p0;
        p8 = d[11] ^ d[10] ^ d[9] ^ d[8] ^ d[7] ^ d[6] ^ d[5];
        p4 = d[11] ^ d[10] ^ d[9] ^ d[8] ^ d[4] ^ d[3] ^ d[2];
        p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
        p1 = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
        p0 = (^d) ^ p8 ^ p4 ^ p2 ^ p1;
        return {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0};
    endfunction

    task automatic load_msgs();
        logic [11:1] d;
        logic [15:0] cw;
        exp_q.delete();
        wr_q.delete();
        for (int i = 0; i < NUM; i++) begin
            for (int b = 0; b < 2; b++) begin
                @(negedge clk);
                tb_we   = 1'b1;
                tb_addr = 8'(SRC + 2 * i + b);
                tb_data = (b == 0) ? msg_lo[i] : msg_hi[i];
            end
            d  = {msg_hi[i][2:0], msg_lo[i]};
            cw = model_enc(d);
            exp_q.push_back({8'(DST + 2 * i), cw[7:0]});
            exp_q.push_back({8'(DST + 2 * i + 1), cw[15:8]});
        end
        @(negedge clk);
        tb_we = 1'b0;
        wr_q.delete();
    endtask

    // Starts a run; returns cycles from start acceptance to done (-1 on timeout).
    task automatic run_engine(input int mid_pulse, output int lat, output logic dropped);
        lat = -1;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        dropped = (bus.done === 1'b0);
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            bus.start = (n == mid_pulse) ? 1'b1 : 1'b0;
            if (bus.done === 1'b1) begin
                lat = n;
                break;
            end
        end
        bus.start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.done !== 1'b0 || bus.mem_we !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl done=%b we=%b required 0/0", bus.done, bus.mem_we);
        end
        checks++;
        if (bus.mem_addr !== 8'h00 || bus.mem_wdata !== 8'h00) begin
            failures++;
            $display("FAIL reset_bus addr=%h wdata=%h required 00/00", bus.mem_addr, bus.mem_wdata);
        end
        reset = 1'b0;
    endtask

    task automatic test_zero();
        int lat;
        logic dropped;
        logic [15:0] e, w;
        for (int i = 0; i < NUM; i++) begin
            msg_lo[i] = 8'(i * 17);
            msg_hi[i] = 8'(i);
        end
        msg_lo[0] = 8'h00;
        msg_hi[0] = 8'h00;
        load_msgs();
        run_engine(0, lat, dropped);
        checks++;
        if (lat !== 61) begin
            failures++;
            $display("FAIL zero_latency got=%0d required=61", lat);
        end
        checks++;
        if (mem[DST] !== 8'h00 || mem[DST + 1] !== 8'h00) begin
            failures++;
            $display("FAIL zero_bytes got=%h/%h required 00/00", mem[DST], mem[DST + 1]);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            w = (wr_q.size() > 0) ? wr_q.pop_front() : 16'hxxxx;
            checks++;
            if (w !== e) begin
                failures++;
                $display("FAIL zero_write got=%h required=%h", w, e);
            end
        end
    endtask

    task automatic test_directed();
        int lat;
        logic dropped;
        logic [15:0] e, w;
        for (int i = 0; i < NUM; i++) begin
            msg_lo[i] = 8'(8'hA5 ^ i);
            msg_hi[i] = 8'(i + 3);
        end
        msg_lo[0] = 8'hFF; msg_hi[0] = 8'h07;
        msg_lo[1] = 8'h01; msg_hi[1] = 8'h00;
        msg_lo[2] = 8'h00; msg_hi[2] = 8'h04;
        msg_lo[3] = 8'h00; msg_hi[3] = 8'hFC;
        load_msgs();
        run_engine(0, lat, dropped);
        checks++;
        if (!dropped || lat !== 61) begin
            failures++;
            $display("FAIL restart_timing dropped=%b latency=%0d required 1/61", dropped, lat);
        end
        checks++;
        if ({mem[DST + 1], mem[DST]} !== 16'hFFFF) begin
            failures++;
            $display("FAIL cw_7ff got=%h required=ffff", {mem[DST + 1], mem[DST]});
        end
        checks++;
        if ({mem[DST + 3], mem[DST + 2]} !== 16'h000F) begin
            failures++;
            $display("FAIL cw_001 got=%h required=000f", {mem[DST + 3], mem[DST + 2]});
        end
        checks++;
        if ({mem[DST + 5], mem[DST + 4]} !== 16'h8117) begin
            failures++;
            $display("FAIL cw_400 got=%h required=8117", {mem[DST + 5], mem[DST + 4]});
        end
        checks++;
        if ({mem[DST + 7], mem[DST + 6]} !== 16'h8117) begin
            failures++;
            $display("FAIL cw_junk_hi got=%h required=8117", {mem[DST + 7], mem[DST + 6]});
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            w = (wr_q.size() > 0) ? wr_q.pop_front() : 16'hxxxx;
            checks++;
            if (w !== e) begin
                failures++;
                $display("FAIL directed_write got=%h required=%h", w, e);
            end
        end
    endtask

    task automatic test_random_mid_start();
        int lat;
        logic dropped;
        logic [15:0] e, w, cw;
        for (int i = 0; i < NUM; i++) begin
            msg_lo[i] = 8'($urandom);
            msg_hi[i] = 8'($urandom);
        end
        load_msgs();
        checks++;
        if (bus.done !== 1'b1) begin
            failures++;
            $display("FAIL done_hold got=%b required=1", bus.done);
        end
        run_engine(12, lat, dropped);
        checks++;
        if (lat !== 61) begin
            failures++;
            $display("FAIL mid_start_latency got=%0d required=61", lat);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            w = (wr_q.size() > 0) ? wr_q.pop_front() : 16'hxxxx;
            checks++;
            if (w !== e) begin
                failures++;
                $display("FAIL random_write got=%h required=%h", w, e);
            end
        end
        for (int i = 0; i < NUM; i++) begin
            cw = {mem[DST + 2 * i + 1], mem[DST + 2 * i]};
            checks++;
            if ((^cw) !== 1'b0) begin
                failures++;
                $display("FAIL even_parity msg=%0d cw=%h parity=%b required=0", i, cw, ^cw);
            end
        end
        checks++;
        if (wr_q.size() != 0) begin
            failures++;
            $display("FAIL extra_writes got=%0d required=0", wr_q.size());
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        int stray;
        logic dropped;
        logic [15:0] e, w;
        for (int i = 0; i < NUM; i++) begin
            msg_lo[i] = 8'($urandom);
            msg_hi[i] = 8'($urandom);
        end
        load_msgs();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (19) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.done !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_addr !== 8'h00) begin
            failures++;
            $display("FAIL midrun_reset done=%b we=%b addr=%h required 0/0/00", bus.done, bus.mem_we, bus.mem_addr);
        end
        reset = 1'b0;
        stray = 0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk);
            #1;
            if (bus.mem_we !== 1'b0 || bus.done !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) begin
            failures++;
            $display("FAIL post_reset_idle active_cycles=%0d required=0", stray);
        end
        load_msgs();
        run_engine(0, lat, dropped);
        checks++;
        if (lat !== 61) begin
            failures++;
            $display("FAIL rerun_latency got=%0d required=61", lat);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            w = (wr_q.size() > 0) ? wr_q.pop_front() : 16'hxxxx;
            checks++;
            if (w !== e) begin
                failures++;
                $display("FAIL rerun_write got=%h required=%h", w, e);
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        tb_we     = 1'b0;
        tb_addr   = 8'h00;
        tb_data   = 8'h00;
        test_reset();
        test_zero();
        test_directed();
        test_random_mid_start();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
